// File: rtl/dfe_pkg.sv
// Shared definitions for the data-frequency engine: default sizing,
// derived widths, the ceiling-log2 helper and the FSM state type that
// the cache block also decodes.
// No ports (package).
package dfe_pkg;

  localparam int unsigned LENGTH_ARRAY_DEF     = 100;
  localparam int unsigned DATA_INDEX_WIDTH_DEF = 32;
  localparam int unsigned BIT_ON_TAILS_DEF     = 7;

  // Ceiling log2, never less than 1 so a one-entry stream still has an index bit.
  function automatic int unsigned log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  localparam int unsigned IDX_W             = log2(LENGTH_ARRAY_DEF);
  localparam int unsigned HADDR_W           = BIT_ON_TAILS_DEF + 1;
  localparam int unsigned LENGTH_HASH_ARRAY = 1 << BIT_ON_TAILS_DEF;
  localparam int unsigned MASK              = LENGTH_HASH_ARRAY - 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, PROBE, CHECK, UPDATE, NEXT, DONE
  } state_e;

endpackage

// File: rtl/hash_probe_unit.sv
// Combinational CHECK-state decision for the hash/occurrence table:
// classifies the addressed slot as empty, matching or colliding, gives the
// next linear-probe slot and the incremented occurrence count.
// Ports:
//   cur_data_i      key being counted
//   hash_value_i    key stored in the addressed slot
//   occurr_value_i  count stored in the addressed slot (0 = empty)
//   slot_i          current slot, probes_i probes already made
//   empty_o/match_o/exhausted_o  decision flags (mutually exclusive)
//   next_slot_o/next_probes_o    values for the next probe
//   inc_value_o     occurrence count + 1
// Build option: HASH_OCCURR_SAT_EN makes the increment saturate at all-ones
// instead of wrapping to 0.
module hash_probe_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SLOT_W = 7
) (
  input  logic [DATA_W-1:0] cur_data_i,
  input  logic [DATA_W-1:0] hash_value_i,
  input  logic [DATA_W-1:0] occurr_value_i,
  input  logic [SLOT_W-1:0] slot_i,
  input  logic [SLOT_W-1:0] probes_i,
  output logic              empty_o,
  output logic              match_o,
  output logic              exhausted_o,
  output logic [SLOT_W-1:0] next_slot_o,
  output logic [SLOT_W-1:0] next_probes_o,
  output logic [DATA_W-1:0] inc_value_o
);
  import dfe_pkg::*;

  always_comb begin
    empty_o       = (occurr_value_i == '0);
    match_o       = !empty_o && (hash_value_i == cur_data_i);
    // probes_i all-ones means every slot of the table has been visited.
    exhausted_o   = !empty_o && !match_o && (probes_i == '1);
    // Slot width equals the hash width, so the natural wrap is the mask.
    next_slot_o   = slot_i + 1'b1;
    next_probes_o = probes_i + 1'b1;
`ifdef HASH_OCCURR_SAT_EN
    inc_value_o   = (occurr_value_i == '1) ? occurr_value_i : occurr_value_i + 1'b1;
`else
    inc_value_o   = occurr_value_i + 1'b1;
`endif
  end

endmodule

// File: rtl/hash_count_core.sv
// Frequency-counting engine: on start, walks the stream cache word by word
// and counts each word in the cache's open-addressed hash/occurrence table
// (linear probing), writing updates through WrEn, then pulses done.
// Ports:
//   clk, rst (sync, active low), start (pulse, IDLE only), hold (freeze)
//   busy, done, overflow (sticky until start), distinct_count
//   index -> DataStream         stream read, data one cycle later
//   HashOccurrAddr -> HashValue/OccurrValue   table read, one cycle later
//   WrEn, NewHashValue, NewOccurrValue        table write
// Build option: HASH_OCCURR_SAT_EN (saturating occurrence increment).
module hash_count_core #(
  parameter  int unsigned LENGTH_ARRAY      = dfe_pkg::LENGTH_ARRAY_DEF,
  parameter  int unsigned DATA_INDEX_WIDTH  = dfe_pkg::DATA_INDEX_WIDTH_DEF,
  parameter  int unsigned BIT_ON_TAILS      = dfe_pkg::BIT_ON_TAILS_DEF,
  localparam int unsigned IDX_W             = dfe_pkg::log2(LENGTH_ARRAY),
  localparam int unsigned HADDR_W           = BIT_ON_TAILS + 1,
  localparam int unsigned LENGTH_HASH_ARRAY = 1 << BIT_ON_TAILS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        hold,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic [HADDR_W-1:0]          distinct_count,
  output logic [IDX_W-1:0]            index,
  input  logic [DATA_INDEX_WIDTH-1:0] DataStream,
  output logic [HADDR_W-1:0]          HashOccurrAddr,
  input  logic [DATA_INDEX_WIDTH-1:0] HashValue,
  input  logic [DATA_INDEX_WIDTH-1:0] OccurrValue,
  output logic                        WrEn,
  output logic [DATA_INDEX_WIDTH-1:0] NewHashValue,
  output logic [DATA_INDEX_WIDTH-1:0] NewOccurrValue
);
  import dfe_pkg::*;

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [DATA_INDEX_WIDTH-1:0] cur_data_q, cur_data_d;
  logic [BIT_ON_TAILS-1:0]     slot_q, slot_d;
  logic [BIT_ON_TAILS-1:0]     probes_q, probes_d;
  logic                        overflow_q, overflow_d;
  logic [HADDR_W-1:0]          distinct_q, distinct_d;
  logic [DATA_INDEX_WIDTH-1:0] new_hash_q, new_hash_d;
  logic [DATA_INDEX_WIDTH-1:0] new_occ_q, new_occ_d;

  logic                        is_empty, is_match, is_exhausted;
  logic [BIT_ON_TAILS-1:0]     next_slot, next_probes;
  logic [DATA_INDEX_WIDTH-1:0] inc_value;

  hash_probe_unit #(
    .DATA_W (DATA_INDEX_WIDTH),
    .SLOT_W (BIT_ON_TAILS)
  ) u_probe (
    .cur_data_i     (cur_data_q),
    .hash_value_i   (HashValue),
    .occurr_value_i (OccurrValue),
    .slot_i         (slot_q),
    .probes_i       (probes_q),
    .empty_o        (is_empty),
    .match_o        (is_match),
    .exhausted_o    (is_exhausted),
    .next_slot_o    (next_slot),
    .next_probes_o  (next_probes),
    .inc_value_o    (inc_value)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cur_data_q <= '0;
      slot_q     <= '0;
      probes_q   <= '0;
      overflow_q <= 1'b0;
      distinct_q <= '0;
      new_hash_q <= '0;
      new_occ_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cur_data_q <= cur_data_d;
      slot_q     <= slot_d;
      probes_q   <= probes_d;
      overflow_q <= overflow_d;
      distinct_q <= distinct_d;
      new_hash_q <= new_hash_d;
      new_occ_q  <= new_occ_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cur_data_d = cur_data_q;
    slot_d     = slot_q;
    probes_d   = probes_q;
    overflow_d = overflow_q;
    distinct_d = distinct_q;
    new_hash_d = new_hash_q;
    new_occ_d  = new_occ_q;
    if (!hold) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            idx_d      = '0;
            overflow_d = 1'b0;
            distinct_d = '0;
            state_d    = FETCH;
          end
        end
        FETCH: state_d = LATCH;
        LATCH: begin
          cur_data_d = DataStream;
          slot_d     = DataStream[BIT_ON_TAILS-1:0];
          probes_d   = '0;
          state_d    = PROBE;
        end
        PROBE: state_d = CHECK;
        CHECK: begin
          if (is_empty) begin
            new_hash_d = cur_data_q;
            new_occ_d  = DATA_INDEX_WIDTH'(1);
            if (distinct_q != HADDR_W'(LENGTH_HASH_ARRAY)) distinct_d = distinct_q + 1'b1;
            state_d    = UPDATE;
          end else if (is_match) begin
            new_hash_d = HashValue;
            new_occ_d  = inc_value;
            state_d    = UPDATE;
          end else if (is_exhausted) begin
            overflow_d = 1'b1;
            state_d    = NEXT;
          end else begin
            slot_d     = next_slot;
            probes_d   = next_probes;
            state_d    = PROBE;
          end
        end
        UPDATE: state_d = NEXT;
        NEXT: begin
          if (idx_q == IDX_W'(LENGTH_ARRAY - 1)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = FETCH;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // index and the table address follow the held registers directly so the
  // cache sees them in FETCH/PROBE and returns data for LATCH/CHECK.
  assign index          = idx_q;
  assign HashOccurrAddr = {1'b0, slot_q};
  assign busy           = (state_q != IDLE);
  // Gated by hold so a frozen DONE state still yields a single pulse.
  assign done           = (state_q == DONE) && !hold;
  // Gated by rst so a reset landing on UPDATE never commits the write.
  assign WrEn           = (state_q == UPDATE) && !hold && rst;
  assign overflow       = overflow_q;
  assign distinct_count = distinct_q;
  assign NewHashValue   = new_hash_q;
  assign NewOccurrValue = new_occ_q;

endmodule
